ddr_cfg_arbiter: RTL
====================

DDR_CFG_ARBITER -- requirements
Module: ddr_cfg_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Parameter: NUM_REQ, 3, number of requesters; fixed at 3 in this revision.
REQ-003 Parameter: TIMEOUT_CYC, 16'hFFFF, number of WAIT cycles before abort (used only with DDR_CFG_ARB_TIMEOUT_EN).
REQ-004 Port: I_sys_clk  in  1  system clock.
REQ-005 Port: I_sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: I_ddr_rdy  in  1  new transactions may start only while high.
REQ-007 Port: I_req  in  3  per-requester request, held until that requester's O_gnt pulse.
REQ-008 Port: I_paddr / I_pwdata  in  96 / 96  packed per-requester address and write data; slice k is [32k+31:32k].
REQ-009 Port: I_pwrite  in  3  per-requester write (1) / read (0).
REQ-010 Port: O_gnt  out  3  one-cycle completion pulse to the owning requester.
REQ-011 Port: O_prdata  out  32  read data, valid while O_gnt is nonzero.
REQ-012 Port: O_paddr / O_pwdata  out  32 / 32  shared register-bus address and write data.
REQ-013 Port: O_pwrite / O_req  out  1 / 1  shared register-bus write flag and request.
REQ-014 Port: I_gnt / I_prdata  in  1 / 32  shared register-bus completion and read data.
REQ-015 Port: O_owner  out  2  index of the current or last owner.
REQ-016 Port: O_timeout  out  1  one-cycle abort pulse.

Function
REQ-017 FSM states SHALL be IDLE, WAIT and RESP.
REQ-018 IDLE: if I_ddr_rdy=1 and any I_req bit is set, the block SHALL pick the winner round-robin, starting from (last owner+1) mod 3.
- On that edge: register O_paddr, O_pwdata, O_pwrite and O_owner from the winner's slice; set O_req=1; go to WAIT.
REQ-019 WAIT: the block SHALL hold O_req and all command outputs stable until I_gnt=1.
- On that edge: O_req<=0, O_pwrite<=0, O_prdata<=I_prdata, O_gnt[owner]<=1; go to RESP.
REQ-020 RESP: O_gnt<=0, the last-owner pointer<=owner, and the FSM goes to IDLE.
- Minimum spacing between consecutive bus requests is therefore 3 cycles.
REQ-021 Latency: I_req sampled high in IDLE gives O_req high on the next cycle; I_gnt high gives O_gnt high on the next cycle.
REQ-022 Dropping I_req or I_ddr_rdy during WAIT/RESP SHALL NOT abort the transaction; it completes normally.
REQ-023 O_prdata SHALL be captured for writes too; requesters ignore it for writes.
REQ-024 Arbitration is only in IDLE; a request arriving during WAIT/RESP waits.
- No requester waits more than 2 transactions once IDLE is reached with its request pending.
REQ-025 I_gnt outside WAIT SHALL be ignored.

Reset
REQ-026 During reset, all outputs SHALL be 0 and the FSM SHALL be IDLE.
REQ-027 The last-owner pointer SHALL reset to 2, so requester 0 has first priority.
REQ-028 Reset asserted mid-transaction SHALL drop O_req immediately; no O_gnt is issued for the lost transaction.

Configuration
REQ-029 With DDR_CFG_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count WAIT cycles, cleared on entering WAIT.
- When it reaches TIMEOUT_CYC: O_req<=0, O_prdata<=32'hDEADBEEF, O_gnt[owner]<=1, O_timeout<=1 (one cycle); go to RESP.
- I_gnt takes priority over timeout in the same cycle.
REQ-030 Without DDR_CFG_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely and O_timeout SHALL be tied 0.

Structure
REQ-031 Package ddr_cfg_arb_pkg SHALL hold: the state encoding, NUM_REQ, the default TIMEOUT_CYC and the 32'hDEADBEEF abort constant.
REQ-032 Round-robin selection SHALL be a combinational sub-module, rr_pick3.
- Inputs: request vector and last-owner pointer.
- Outputs: grant index and a valid flag.

Verification
REQ-033 Single read: req1 reads 0x4120906C; slave returns I_gnt after 4 cycles with 0x80000000.
- Required: O_gnt=3'b010 for one cycle with O_prdata=0x80000000.
REQ-034 All three request together from reset, each gnt after 1 cycle.
- Required: service order 0,1,2; O_req rising edges exactly 3 cycles apart.
REQ-035 req0 held continuously with req2 pending.
- Required: order 0,2,0,2; req0 never granted twice in a row while req2 waits.
REQ-036 I_ddr_rdy=0 with req0 pending: O_req stays 0.
- I_ddr_rdy then goes 1: O_req=1 on the next cycle.
- I_ddr_rdy dropped during WAIT: transaction still completes.
REQ-037 Timeout build, TIMEOUT_CYC=16, slave never grants.
- Required: O_req high for 16 WAIT cycles, then O_timeout and O_gnt pulse with O_prdata=0xDEADBEEF.
- Without the macro, O_req stays high forever.
REQ-038 Reset asserted in WAIT.
- Required: O_req=0 immediately and no O_gnt; after release, requester 0 has priority.

Source files
------------

// File: rtl/ddr_cfg_arb_pkg.sv
// Shared constants, state encoding and command payload for ddr_cfg_arbiter.
package ddr_cfg_arb_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned TMO_W   = 16;

  localparam logic [TMO_W-1:0]  TIMEOUT_CYC_DEF = 16'hFFFF;
  localparam logic [DATA_W-1:0] ABORT_DATA      = 32'hDEADBEEF;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // One requester's register-bus command
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
  } cmd_t;

  // Requester index that is ofs places after base, wrapping over NUM_REQ
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] base, input int ofs);
    return IDX_W'((32'(base) + 32'(ofs)) % NUM_REQ);
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters, starting after last.
module rr_pick3
  import ddr_cfg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   idx_c,
  output logic               valid_c
);

  logic [IDX_W-1:0] cand;

  // Scan from furthest to nearest so the requester right after last wins
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      cand = rr_next(last, i);
      if (req[cand]) begin
        idx_c   = cand;
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_cfg_arbiter.sv
// Three-way round-robin arbiter onto a shared DDR configuration register bus.
// Optional WAIT abort timer enabled by defining DDR_CFG_ARB_TIMEOUT_EN.
module ddr_cfg_arbiter #(
  parameter int unsigned NUM_REQ     = ddr_cfg_arb_pkg::NUM_REQ,
  parameter logic [15:0] TIMEOUT_CYC = ddr_cfg_arb_pkg::TIMEOUT_CYC_DEF
) (
  input  logic                I_sys_clk,
  input  logic                I_sys_rst_n,
  input  logic                I_ddr_rdy,
  input  logic [NUM_REQ-1:0]  I_req,
  input  logic [32*NUM_REQ-1:0] I_paddr,
  input  logic [32*NUM_REQ-1:0] I_pwdata,
  input  logic [NUM_REQ-1:0]  I_pwrite,
  output logic [NUM_REQ-1:0]  O_gnt,
  output logic [31:0]         O_prdata,
  output logic [31:0]         O_paddr,
  output logic [31:0]         O_pwdata,
  output logic                O_pwrite,
  output logic                O_req,
  input  logic                I_gnt,
  input  logic [31:0]         I_prdata,
  output logic [1:0]          O_owner,
  output logic                O_timeout
);

  import ddr_cfg_arb_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  cmd_t               cmd_q, cmd_d;
  logic               req_q, req_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_valid_c;
  cmd_t               cmd_a [NUM_REQ];

`ifdef DDR_CFG_ARB_TIMEOUT_EN
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`else
  logic               unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // Unpack the per-requester command slices
  always_comb begin
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cmd_a[k].addr  = I_paddr[k*DATA_W +: DATA_W];
      cmd_a[k].wdata = I_pwdata[k*DATA_W +: DATA_W];
      cmd_a[k].write = I_pwrite[k];
    end
  end

  rr_pick3 u_pick (
    .req     (I_req),
    .last    (last_q),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    req_d    = req_q;
    prdata_d = prdata_q;
    gnt_d    = '0;
`ifdef DDR_CFG_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (I_ddr_rdy && pick_valid_c) begin
          owner_d = pick_idx_c;
          cmd_d   = cmd_a[pick_idx_c];
          req_d   = 1'b1;
          state_d = ST_WAIT;
`ifdef DDR_CFG_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (I_gnt) begin
          req_d       = 1'b0;
          cmd_d.write = 1'b0;
          prdata_d    = I_prdata;
          gnt_d       = NUM_REQ'(1) << owner_q;
          state_d     = ST_RESP;
        end
`ifdef DDR_CFG_ARB_TIMEOUT_EN
        else if (TMO_W'(cnt_q + 16'd1) == TIMEOUT_CYC) begin
          req_d     = 1'b0;
          prdata_d  = ABORT_DATA;
          gnt_d     = NUM_REQ'(1) << owner_q;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = TMO_W'(cnt_q + 16'd1);
        end
`endif
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; last owner resets to 2 so requester 0 goes first
  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      last_q   <= IDX_W'(2);
      cmd_q    <= '0;
      req_q    <= 1'b0;
      prdata_q <= '0;
      gnt_q    <= '0;
`ifdef DDR_CFG_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cmd_q    <= cmd_d;
      req_q    <= req_d;
      prdata_q <= prdata_d;
      gnt_q    <= gnt_d;
`ifdef DDR_CFG_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign O_gnt    = gnt_q;
  assign O_prdata = prdata_q;
  assign O_paddr  = cmd_q.addr;
  assign O_pwdata = cmd_q.wdata;
  assign O_pwrite = cmd_q.write;
  assign O_req    = req_q;
  assign O_owner  = owner_q;
`ifdef DDR_CFG_ARB_TIMEOUT_EN
  assign O_timeout = timeout_q;
`else
  assign O_timeout = 1'b0;
`endif

endmodule
